spi_master_seq: RTL and testbench
=================================

Name: spi_master_seq

Overview:
- SPI master (initiator) that drives the slave command state machine on the digitizer CycloneIII from the controller side.
- Issues one command word carrying a 4-bit opcode, then one of:
  - a write data word;
  - a single read word;
  - a burst of FIFO packet words.
- Sits between the host-side register/control logic and the board SPI pins; generates SCLK, CS_n and MOSI, and samples MISO.

Parameters:
- WORD_W, 16, bits per SPI word (command and data); legal values 8..32.
- CLK_DIV, 4, clk cycles per SCLK half-period; minimum 1.
- GAP_CYC, 4, clk cycles of SCLK-idle gap between words inside one transaction (CS_n held low); minimum 2, so the slave can pre-read its FIFO.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  request pulse; sampled only in IDLE
- cmd  in  4  opcode: CMD_RD, CMD_WR or CMD_FIFO
- addr  in  WORD_W-4  address field of the command word
- wr_data  in  WORD_W  data word sent for CMD_WR
- pk_sz  in  8  FIFO burst size; pk_sz+1 words are read
- sclk  out  1  SPI clock, mode 0, idles low
- cs_n  out  1  chip select, active low
- mosi  out  1  master out, MSB first
- miso  in  1  slave out
- busy  out  1  high from the accept cycle until done
- done  out  1  one-cycle pulse at transaction end
- err  out  1  valid with done; 1 means an illegal opcode was rejected
- rd_data  out  WORD_W  last received word
- rd_valid  out  1  one-cycle pulse per received word

Behaviour:
- Reset (async, rst=1): sclk=0, cs_n=1, mosi=0, busy=0, done=0, err=0, rd_valid=0, rd_data=0; state=IDLE; all counters=0.
  - Reset mid-transaction forces cs_n=1 and sclk=0 immediately (asynchronously).
- Command word: {cmd, addr}. cmd, addr, wr_data and pk_sz are latched on the accept cycle; later input changes are ignored.
- States: IDLE, SETUP, SHIFT, GAP, FINISH.
- IDLE:
  - start=1 with a legal cmd: latch inputs; busy=1 next cycle; go to SETUP.
  - start=1 with an illegal cmd: go to FINISH with err=1; cs_n stays high and there is no SPI activity.
  - start while busy is ignored.
- SETUP:
  - cs_n=0; mosi=bit[WORD_W-1] of the current word.
  - Hold CLK_DIV cycles, then go to SHIFT.
- SHIFT:
  - Per bit: sclk rises after a half-period; miso is sampled on the same clk edge that drives sclk high.
  - After another half-period sclk falls and mosi advances to the next bit.
  - One word takes 2*CLK_DIV*WORD_W cycles; a 16-bit bit counter wraps to 0 at end of word.
  - After the last falling edge, a data word captured during a read phase loads rd_data and pulses rd_valid (same cycle).
- Word sequencing:
  - CMD_WR: command word, then wr_data (miso ignored).
  - CMD_RD: command word, then 1 read word (mosi=0).
  - CMD_FIFO: command word, then pk_sz+1 read words. An 8-bit down-counter is loaded with pk_sz and decremented after each word; the last word is the one read while the counter is 0. pk_sz=255 gives 256 words.
  - Any word boundary that is not the last goes to GAP: sclk=0, cs_n=0 for GAP_CYC cycles, then SETUP-free direct SHIFT, with mosi preloaded at GAP entry.
- FINISH:
  - After the last word: cs_n=1 and sclk=0.
  - done=1 and busy=0 on the same cycle; err as determined.
  - Return to IDLE next cycle; start is accepted again from that IDLE cycle.
- Command word data on miso is discarded (rd_valid not pulsed).

Optional Feature:
- SPI_MASTER_SEQ_LOOPBACK_EN:
  - Defined: the internal sample source is mosi instead of miso (self-test); the miso pin is ignored.
  - Undefined: miso is used.
- Port list is identical in both builds.

Decomposition:
- Shared package spi_pkg holds:
  - opcode constants CMD_RD=4'h1, CMD_WR=4'h2, CMD_FIFO=4'h3;
  - state encoding typedef;
  - a cmd-legality function.
- One natural sub-module: spi_shift_engine, covering the SCLK divider plus bit shifter/sampler for one word. It has start_word/word_done handshake, tx word in and rx word out. The sequencer FSM stays in the top.

Test Plan:
- Reset mid-SHIFT (CMD_FIFO, pk_sz=3): assert rst while in SHIFT -> cs_n=1, sclk=0, busy=0 in the same cycle. After release, a new CMD_RD completes normally.
- CMD_WR, addr=12'h0A5, wr_data=16'hBEEF, CLK_DIV=2, GAP_CYC=4:
  - mosi carries 16'h20A5 then 16'hBEEF, MSB first; 32 sclk rising edges total; cs_n low throughout.
  - done pulses once; rd_valid never asserts.
- CMD_RD, slave model returns 16'h1234 -> exactly one rd_valid with rd_data=16'h1234, then done with err=0.
- CMD_FIFO, pk_sz=3, slave returns 16'h0001..16'h0004 -> four rd_valid pulses in order; each inter-word gap is ≥4 cycles with sclk low and cs_n low.
- cmd=4'hF -> no cs_n activity; done=1 and err=1 one cycle after accept. A second start asserted during a busy CMD_RD is ignored.
- SPI_MASTER_SEQ_LOOPBACK_EN defined, CMD_WR wr_data=16'hBEEF with miso tied 0 -> internal shift register captures 16'hBEEF (rd_data unchanged for WR). With CMD_RD, rd_data equals the transmitted all-zero read word.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command master: opcodes, the sequencer
// state encoding and the opcode-legality check.
package spi_pkg;

  // Opcodes understood by the slave command state machine
  localparam logic [3:0] CMD_RD   = 4'h1;
  localparam logic [3:0] CMD_WR   = 4'h2;
  localparam logic [3:0] CMD_FIFO = 4'h3;

  // Sequencer state encoding
  typedef logic [2:0] state_t;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_SHIFT  = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  // True for the opcodes the slave accepts; anything else is rejected
  // without touching the SPI pins.
  function automatic logic cmd_legal(input logic [3:0] c);
    return (c == CMD_RD) || (c == CMD_WR) || (c == CMD_FIFO);
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// One-word SPI mode-0 engine: SCLK divider, MSB-first transmit shifter
// and receive sampler. load_word preloads the transmit word (mosi shows
// its MSB from the next cycle); start_word runs one full word, which ends
// with a one-cycle word_done pulse after the last SCLK falling edge.
module spi_shift_engine #(
  parameter int WORD_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_word,
  input  logic [WORD_W-1:0] tx_word,
  input  logic              start_word,
  input  logic              sample_in,
  output logic              sclk,
  output logic              mosi,
  output logic              word_done,
  output logic [WORD_W-1:0] rx_word
);

  logic [WORD_W-1:0] tx_sr;
  logic [15:0]       div_cnt;
  logic [15:0]       bit_cnt;
  logic              running;

  assign mosi = tx_sr[WORD_W-1];

  // Half-period divider; sample on the edge that raises sclk, shift the
  // transmit word on the edge that lowers it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sr     <= '0;
      rx_word   <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      running   <= 1'b0;
      sclk      <= 1'b0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (load_word) begin
        tx_sr <= tx_word;
      end
      if (start_word) begin
        running <= 1'b1;
        div_cnt <= '0;
        bit_cnt <= '0;
        sclk    <= 1'b0;
      end else if (running) begin
        if (div_cnt == 16'(CLK_DIV - 1)) begin
          div_cnt <= '0;
          if (!sclk) begin
            sclk    <= 1'b1;
            rx_word <= {rx_word[WORD_W-2:0], sample_in};
          end else begin
            sclk  <= 1'b0;
            tx_sr <= {tx_sr[WORD_W-2:0], 1'b0};
            if (bit_cnt == 16'(WORD_W - 1)) begin
              bit_cnt   <= '0;
              running   <= 1'b0;
              word_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 16'd1;
            end
          end
        end else begin
          div_cnt <= div_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_master_seq.sv
// SPI master for the digitizer slave command interface. Sends a command
// word {cmd, addr} followed by a write word, one read word or a burst of
// pk_sz+1 FIFO read words, all under one CS_n assertion.
// Build option SPI_MASTER_SEQ_LOOPBACK_EN: when defined, the receive
// sampler takes mosi instead of miso (self-test); ports are unchanged.
module spi_master_seq
  import spi_pkg::*;
#(
  parameter int WORD_W  = 16,
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        cmd,
  input  logic [WORD_W-5:0] addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [7:0]        pk_sz,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid
);

  state_t            state;
  logic [15:0]       cnt;
  logic [3:0]        cmd_reg;
  logic [WORD_W-1:0] wr_data_reg;
  logic [7:0]        pk_cnt;
  logic              in_cmd;

  logic              load_word;
  logic [WORD_W-1:0] tx_word;
  logic              start_word;
  logic              word_done;
  logic [WORD_W-1:0] rx_word;
  logic              sample_src;
  logic              last_word;

`ifdef SPI_MASTER_SEQ_LOOPBACK_EN
  // Self-test: hear our own transmit line; the pin is deliberately masked.
  assign sample_src = mosi | (miso & 1'b0);
`else
  assign sample_src = miso;
`endif

  // The data word just finished is the last one for RD/WR, or for FIFO
  // when the burst down-counter has reached zero.
  assign last_word = !in_cmd && ((cmd_reg != CMD_FIFO) || (pk_cnt == 8'd0));

  spi_shift_engine #(
    .WORD_W  (WORD_W),
    .CLK_DIV (CLK_DIV)
  ) u_eng (
    .clk        (clk),
    .rst        (rst),
    .load_word  (load_word),
    .tx_word    (tx_word),
    .start_word (start_word),
    .sample_in  (sample_src),
    .sclk       (sclk),
    .mosi       (mosi),
    .word_done  (word_done),
    .rx_word    (rx_word)
  );

  // Engine control: preload the next word at accept / gap entry, and
  // kick off shifting when the setup or gap interval expires.
  always_comb begin
    load_word  = 1'b0;
    tx_word    = '0;
    start_word = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && cmd_legal(cmd)) begin
          load_word = 1'b1;
          tx_word   = {cmd, addr};
        end
      end
      ST_SETUP: begin
        if (cnt == 16'(CLK_DIV - 1)) start_word = 1'b1;
      end
      ST_SHIFT: begin
        if (word_done && !last_word) begin
          load_word = 1'b1;
          tx_word   = (in_cmd && (cmd_reg == CMD_WR)) ? wr_data_reg : '0;
        end
      end
      ST_GAP: begin
        if (cnt == 16'(GAP_CYC - 1)) start_word = 1'b1;
      end
      default: ;
    endcase
  end

  // Transaction sequencer: accept, setup, per-word shift/gap, finish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cmd_reg     <= '0;
      wr_data_reg <= '0;
      pk_cnt      <= '0;
      in_cmd      <= 1'b0;
      cs_n        <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (cmd_legal(cmd)) begin
              cmd_reg     <= cmd;
              wr_data_reg <= wr_data;
              pk_cnt      <= pk_sz;
              in_cmd      <= 1'b1;
              cnt         <= '0;
              busy        <= 1'b1;
              cs_n        <= 1'b0;
              state       <= ST_SETUP;
            end else begin
              done  <= 1'b1;
              err   <= 1'b1;
              state <= ST_FINISH;
            end
          end
        end
        ST_SETUP: begin
          if (cnt == 16'(CLK_DIV - 1)) begin
            cnt   <= '0;
            state <= ST_SHIFT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_SHIFT: begin
          if (word_done) begin
            if (!in_cmd && (cmd_reg != CMD_WR)) begin
              rd_data  <= rx_word;
              rd_valid <= 1'b1;
            end
            if (last_word) begin
              cs_n  <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              err   <= 1'b0;
              state <= ST_FINISH;
            end else begin
              if (!in_cmd) pk_cnt <= pk_cnt - 8'd1;
              in_cmd <= 1'b0;
              cnt    <= '0;
              state  <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (cnt == 16'(GAP_CYC - 1)) begin
            cnt   <= '0;
            state <= ST_SHIFT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_FINISH: begin
          done  <= 1'b0;
          err   <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_seq.sv
// Self-checking bench for spi_master_seq: table of directed transactions,
// randomized transactions against a transaction-level model, and hand
// sequences for reset-in-flight and ignored starts.
module tb_spi_master_seq;
  import spi_pkg::*;

  localparam int W   = 16;
  localparam int CD  = 2;
  localparam int GAP = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic [3:0]    cmd;
  logic [W-5:0]  addr;
  logic [W-1:0]  wr_data;
  logic [7:0]    pk_sz;
  logic          sclk, cs_n, mosi, miso, busy, done, err, rd_valid;
  logic [W-1:0]  rd_data;

  spi_master_seq #(.WORD_W(W), .CLK_DIV(CD), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .addr(addr),
    .wr_data(wr_data), .pk_sz(pk_sz), .sclk(sclk), .cs_n(cs_n),
    .mosi(mosi), .miso(miso), .busy(busy), .done(done), .err(err),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- slave model / bus monitor ----------------
  logic [W-1:0] resp [0:299];
  int           tx_base = 0;
  int           rise_cnt = 0, done_cnt = 0, csl_cnt = 0, bad_cs = 0, rdv_cnt = 0, low_run = 0;
  logic         mosi_log [0:32767];
  int           low_log  [0:32767];
  logic [W-1:0] rdv_log  [0:4095];
  logic         sclk_q = 1'b0;
  int           rel;

  // Slave drives the bit the master will sample at the next rising edge
  always_comb begin
    miso = 1'b0;
    rel  = rise_cnt - tx_base;
    if (rel >= 0 && rel < 300 * W) miso = resp[rel / W][(W - 1) - (rel % W)];
  end

  always @(negedge clk) begin
    if (!cs_n) csl_cnt <= csl_cnt + 1;
    if (sclk && !sclk_q) begin
      mosi_log[rise_cnt] <= mosi;
      low_log[rise_cnt]  <= low_run;
      rise_cnt           <= rise_cnt + 1;
      if (cs_n) bad_cs <= bad_cs + 1;
    end else if (busy && cs_n) begin
      bad_cs <= bad_cs + 1;
    end
    low_run <= sclk ? 0 : low_run + 1;
    sclk_q  <= sclk;
    if (rd_valid) begin
      rdv_log[rdv_cnt] <= rd_data;
      rdv_cnt          <= rdv_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  // ---------------- transaction-level model ----------------
  logic [W-1:0] model_rd = '0;

  function automatic int words_for(input logic [3:0] c, input logic [7:0] pk);
    if (!cmd_legal(c)) return 0;
    if (c == CMD_FIFO) return int'(pk) + 2;
    return 2;
  endfunction

  task automatic run_txn(input logic [3:0] c, input logic [W-5:0] a, input logic [W-1:0] wd,
                         input logic [7:0] pk, input bit poke, input logic exp_err,
                         input int exp_words, input logic [W-1:0] seed);
    int b_r, b_d, b_c, b_v, b_b, cyc;
    bit got;
    logic [W-1:0] exp_rd[$];
    logic [W-1:0] word, ew;
    bit word_ok, gap_ok;
    int first_bad;
    resp[0] = W'($urandom);
    for (int i = 1; i < 300; i++) resp[i] = (seed != 0) ? W'(seed + W'(i - 1)) : W'($urandom);
    if (exp_words > 0 && c != CMD_WR)
      for (int i = 1; i < exp_words; i++) begin
`ifdef SPI_MASTER_SEQ_LOOPBACK_EN
        exp_rd.push_back('0);
`else
        exp_rd.push_back(resp[i]);
`endif
      end
    @(negedge clk);
    b_r = rise_cnt; b_d = done_cnt; b_c = csl_cnt; b_v = rdv_cnt; b_b = bad_cs;
    tx_base = rise_cnt;
    @(posedge clk); #1;
    start = 1'b1; cmd = c; addr = a; wr_data = wd; pk_sz = pk;
    @(posedge clk); #1;
    start = 1'b0; cmd = 4'($urandom); addr = (W-4)'($urandom); wr_data = W'($urandom); pk_sz = 8'($urandom);
    @(negedge clk);
    if (exp_err) begin
      chk("illegal_done_next", {30'd0, done, err}, 32'h3);
      chk("illegal_busy", {31'd0, busy}, 32'h0);
    end else begin
      chk("busy_after_accept", {31'd0, busy}, 32'h1);
    end
    got = done;
    cyc = 0;
    while (!got && cyc < 40000) begin
      if (poke) begin
        start = (cyc == 3);
        cmd   = CMD_WR;
      end
      @(negedge clk);
      cyc++;
      got = done;
    end
    start = 1'b0;
    chk("done_seen", {31'd0, got}, 32'h1);
    chk("busy_err_at_done", {30'd0, busy, err}, {30'd0, 1'b0, exp_err});
    repeat (3) @(negedge clk);
    chk("sclk_rises", 32'(rise_cnt - b_r), 32'(exp_words * W));
    chk("done_pulses", 32'(done_cnt - b_d), 32'd1);
    chk("cs_violations", 32'(bad_cs - b_b), 32'd0);
    if (exp_words == 0) chk("cs_idle_illegal", 32'(csl_cnt - b_c), 32'd0);
    chk("rd_valid_count", 32'(rdv_cnt - b_v), 32'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < rdv_cnt - b_v; i++)
      chk($sformatf("rd_word[%0d]", i), 32'(rdv_log[b_v + i]), 32'(exp_rd[i]));
    if (exp_rd.size() > 0) model_rd = exp_rd[exp_rd.size() - 1];
    chk("rd_data_hold", 32'(rd_data), 32'(model_rd));
    word_ok = 1'b1; gap_ok = 1'b1; first_bad = -1;
    for (int k = 0; k < exp_words && (rise_cnt - b_r) >= exp_words * W; k++) begin
      word = '0;
      for (int bt = 0; bt < W; bt++) word = {word[W-2:0], mosi_log[b_r + k * W + bt]};
      ew = (k == 0) ? {c, a} : ((c == CMD_WR) ? wd : '0);
      if (word !== ew && word_ok) begin word_ok = 1'b0; first_bad = k; end
      if (k > 0 && low_log[b_r + k * W] < GAP) gap_ok = 1'b0;
    end
    if (exp_words > 0) begin
      chk($sformatf("mosi_words(first bad %0d)", first_bad), {31'd0, word_ok}, 32'h1);
      chk("inter_word_gap", {31'd0, gap_ok}, 32'h1);
    end
`ifdef SPI_MASTER_SEQ_LOOPBACK_EN
    if (c == CMD_WR) chk("loopback_rx", 32'(dut.u_eng.rx_word), 32'(wd));
`endif
    $display("txn cmd=%h addr=%h wd=%h pk=%0d words=%0d err=%0b rd=%0d", c, a, wd, pk,
             exp_words, exp_err, exp_rd.size());
  endtask

  typedef struct {
    logic [3:0]   c;
    logic [W-5:0] a;
    logic [W-1:0] wd;
    logic [7:0]   pk;
    bit           poke;
    logic [W-1:0] seed;
    logic         exp_err;
    int           exp_words;
  } vec_t;

  vec_t vecs [0:8];

  initial begin
    int b_d, cyc;
    logic [3:0] rc;
    logic [7:0] rp;
    vecs[0] = '{CMD_WR,   12'h0A5, 16'hBEEF, 8'd0,   1'b0, 16'h0000, 1'b0, 2};
    vecs[1] = '{CMD_RD,   12'h123, 16'h0000, 8'd0,   1'b1, 16'h1234, 1'b0, 2};
    vecs[2] = '{CMD_FIFO, 12'h3C3, 16'h0000, 8'd3,   1'b0, 16'h0001, 1'b0, 5};
    vecs[3] = '{4'hF,     12'h000, 16'h0000, 8'd0,   1'b0, 16'h0000, 1'b1, 0};
    vecs[4] = '{4'h0,     12'hFFF, 16'h5555, 8'd9,   1'b0, 16'h0000, 1'b1, 0};
    vecs[5] = '{CMD_FIFO, 12'h001, 16'h0000, 8'd0,   1'b0, 16'h0000, 1'b0, 2};
    vecs[6] = '{CMD_WR,   12'hFFF, 16'h8001, 8'd7,   1'b0, 16'h0000, 1'b0, 2};
    vecs[7] = '{CMD_FIFO, 12'h7E7, 16'h0000, 8'd255, 1'b0, 16'h0000, 1'b0, 257};
    vecs[8] = '{4'h4,     12'h0AA, 16'h0000, 8'd1,   1'b0, 16'h0000, 1'b1, 0};

    rst = 1'b1; start = 1'b0; cmd = '0; addr = '0; wr_data = '0; pk_sz = '0;
    for (int i = 0; i < 300; i++) resp[i] = '0;
    #2;
    chk("reset_pins", {28'd0, sclk, cs_n, mosi, busy}, 32'h4);
    chk("reset_flags", {29'd0, done, err, rd_valid}, 32'h0);
    chk("reset_rd_data", 32'(rd_data), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 9; i++)
      run_txn(vecs[i].c, vecs[i].a, vecs[i].wd, vecs[i].pk, vecs[i].poke,
              vecs[i].exp_err, vecs[i].exp_words, vecs[i].seed);

    // Reset while shifting a FIFO burst
    @(negedge clk);
    b_d = done_cnt;
    tx_base = rise_cnt;
    @(posedge clk); #1;
    start = 1'b1; cmd = CMD_FIFO; addr = 12'h055; pk_sz = 8'd3;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (rise_cnt - tx_base < 21 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_shift", {31'd0, (rise_cnt - tx_base >= 21)}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("midreset_pins", {29'd0, cs_n, sclk, busy}, 32'h4);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset_no_done", 32'(done_cnt - b_d), 32'd0);
    model_rd = '0;
    run_txn(CMD_RD, 12'h321, 16'h0, 8'd0, 1'b0, 1'b0, 2, 16'h0);

    // Randomized transactions against the model
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0: rc = CMD_RD;
        1: rc = CMD_WR;
        2: rc = CMD_FIFO;
        default: rc = 4'($urandom);
      endcase
      rp = 8'($urandom_range(0, 6));
      run_txn(rc, (W-4)'($urandom), W'($urandom), rp, 1'($urandom), !cmd_legal(rc),
              words_for(rc, rp), 16'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
